// File: rtl/pulse_stretcher_if.sv
// ============================================================================
// pulse_stretcher_if : strobe request / stretched level interface
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_stretcher_if #(
  parameter int PEND_W = 2
);
  logic              strobe_n;
  logic              clear_ovf;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output strobe_n, clear_ovf,
    input  level_out, busy, pending, overflow
  );

  modport slave (
    input  strobe_n, clear_ovf,
    output level_out, busy, pending, overflow
  );
endinterface

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// pulse_stretcher : active-low strobes -> fixed-length high levels, queued
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 3,
  parameter int PEND_W      = 2,
  parameter int CNT_W       = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pulse_stretcher_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] C_MAX_PEND  = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] C_ONE       = PEND_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [PEND_W-1:0] pending;
  logic              level;
  logic              busy;
  logic              overflow;

  logic req;
  logic cnt_zero;
  logic at_max;
  logic queue_req;
  logic drop;

  always_comb begin
    req       = ~bus.strobe_n;
    cnt_zero  = (counter == '0);
    at_max    = (pending == C_MAX_PEND);
    // Requests are queued during HOLD and all but the final GAP cycle;
    // on the final GAP cycle a request either launches or cancels a dequeue.
    queue_req = req && ((state == HOLD) || ((state == GAP) && !cnt_zero));
    drop      = queue_req && at_max;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      pending  <= '0;
      level    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // A fresh drop wins over a simultaneous clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clear_ovf) begin
        overflow <= 1'b0;
      end

      if (queue_req && !at_max) begin
        pending <= pending + C_ONE;
      end

      case (state)
        IDLE: begin
          if (req) begin
            state   <= HOLD;
            counter <= C_HOLD_LAST;
            level   <= 1'b1;
            busy    <= 1'b1;
          end
        end

        HOLD: begin
          if (!cnt_zero) begin
            counter <= counter - C_CNT_ONE;
          end else begin
            state   <= GAP;
            counter <= C_GAP_LAST;
            level   <= 1'b0;
          end
        end

        GAP: begin
          if (!cnt_zero) begin
            counter <= counter - C_CNT_ONE;
          end else if ((pending != '0) || req) begin
            state   <= HOLD;
            counter <= C_HOLD_LAST;
            level   <= 1'b1;
            // A queued launch with a new request leaves the count unchanged;
            // a direct launch from an empty queue never touches it.
            if (!req) begin
              pending <= pending - C_ONE;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          counter <= '0;
          pending <= '0;
          level   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_out = level;
  assign bus.busy      = busy;
  assign bus.pending   = pending;
  assign bus.overflow  = overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// tb_pulse_stretcher : directed + randomized checks against a slot-based model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int MAXP = 3;
  localparam int PW   = 2;
  localparam int SLOT = HOLD + GAP;

  logic clk = 1'b0;
  logic reset;

  pulse_stretcher_if #(.PEND_W(PW)) bus ();

  pulse_stretcher #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .MAX_PENDING (MAXP),
    .PEND_W      (PW),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the current level+gap slot (-1 when idle),
  // number of queued requests, and the sticky overflow flag.
  int m_pos  = -1;
  int m_pend = 0;
  int m_ovf  = 0;
  bit m_live = 1'b0;
  int m_req;
  int m_launch;
  int m_drop;

  always @(posedge clk) begin
    m_req  = (bus.strobe_n == 1'b0) ? 1 : 0;
    m_drop = 0;
    if (reset) begin
      m_pos  = -1;
      m_pend = 0;
      m_ovf  = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (m_pos < 0) begin
        if (m_req != 0) m_pos = 0;
      end else if (m_pos == SLOT - 1) begin
        m_launch = (m_pend > 0 || m_req != 0) ? 1 : 0;
        m_pend   = m_pend + m_req - m_launch;
        m_pos    = (m_launch != 0) ? 0 : -1;
      end else begin
        if (m_req != 0) begin
          if (m_pend == MAXP) m_drop = 1;
          else m_pend++;
        end
        m_pos++;
      end
      if (m_drop != 0) m_ovf = 1;
      else if (bus.clear_ovf) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_level",    int'(bus.level_out), (m_pos >= 0 && m_pos < HOLD) ? 1 : 0);
      check("model_busy",     int'(bus.busy),      (m_pos >= 0) ? 1 : 0);
      check("model_pending",  int'(bus.pending),   m_pend);
      check("model_overflow", int'(bus.overflow),  m_ovf);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.strobe_n = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp_lvl  [7] = '{1, 1, 1, 1, 0, 0, 0};
  int exp_busy [7] = '{1, 1, 1, 1, 1, 1, 0};
  int exp_lvl2 [13] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  int rises;
  bit prev;
  int dens;

  initial begin
    reset         = 1'b1;
    bus.strobe_n  = 1'b1;
    bus.clear_ovf = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_level", int'(bus.level_out), 0);
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_pend",  int'(bus.pending), 0);
    check("reset_ovf",   int'(bus.overflow), 0);

    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_level", int'(bus.level_out), 0);
    end

    // Single strobe
    bus.strobe_n = 1'b0;
    tick();
    bus.strobe_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("single_level", int'(bus.level_out), exp_lvl[i]);
      check("single_busy",  int'(bus.busy), exp_busy[i]);
      check("single_pend",  int'(bus.pending), 0);
      tick();
    end
    idle(5);

    // Two strobes two cycles apart
    bus.strobe_n = 1'b0;
    tick();
    bus.strobe_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 1) bus.strobe_n = 1'b0;
      if (i == 2) begin
        bus.strobe_n = 1'b1;
        check("two_pend_q", int'(bus.pending), 1);
      end
      if (i == 6) check("two_pend_0", int'(bus.pending), 0);
      check("two_level", int'(bus.level_out), exp_lvl2[i]);
      tick();
    end
    idle(5);

    // Continuous low for six sampled edges: saturation and overflow
    bus.strobe_n = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.level_out && !prev) rises++;
      prev = bus.level_out;
    end
    bus.strobe_n = 1'b1;
    check("sat_pend", int'(bus.pending), 3);
    check("sat_ovf",  int'(bus.overflow), 1);
    for (int i = 0; i < 34; i++) begin
      tick();
      if (bus.level_out && !prev) rises++;
      prev = bus.level_out;
    end
    check("sat_levels", rises, 4);
    check("sat_ovf_hold", int'(bus.overflow), 1);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    check("clear_ovf", int'(bus.overflow), 0);
    idle(3);

    // Strobe on the final gap cycle with an empty queue
    bus.strobe_n = 1'b0;
    tick();
    bus.strobe_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("lastgap_low", int'(bus.level_out), 0);
    bus.strobe_n = 1'b0;
    tick();
    bus.strobe_n = 1'b1;
    check("lastgap_relaunch", int'(bus.level_out), 1);
    check("lastgap_pend",     int'(bus.pending), 0);
    idle(12);

    // Reset mid-HOLD with two queued requests
    bus.strobe_n = 1'b0;
    tick();
    tick();
    tick();
    bus.strobe_n = 1'b1;
    check("rst_pre_pend", int'(bus.pending), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_level", int'(bus.level_out), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_pend",  int'(bus.pending), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_no_replay", int'(bus.level_out), 0);
    end

    // Randomized traffic at varying request densities
    for (int seg = 0; seg < 8; seg++) begin
      dens = (seg % 4 == 0) ? 5 : (seg % 4 == 1) ? 30 : (seg % 4 == 2) ? 70 : 95;
      for (int i = 0; i < 500; i++) begin
        bus.strobe_n  = ($urandom_range(0, 99) < dens) ? 1'b0 : 1'b1;
        bus.clear_ovf = ($urandom_range(0, 39) == 0);
        reset         = ($urandom_range(0, 599) == 0);
        tick();
      end
    end
    reset         = 1'b0;
    bus.clear_ovf = 1'b0;
    idle(40);
    check("end_idle_busy", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Inverse of the button one-shot path. Accepts single-cycle active-low strobes, such as one-shot outputs or decoded command pulses, and regenerates each one as an active-high level held for a fixed number of cycles. Successive levels are separated by a guaranteed low gap. Strobes that arrive while a level or gap is in progress are counted and replayed in order, with saturation and a sticky overflow flag. Sits between strobe sources and slow level-sensitive consumers: LED drivers, debug pins, multi-cycle enables.

Parameters:
HOLD_CYCLES, 4, cycles level_out stays high per strobe; legal range >= 1
GAP_CYCLES, 2, minimum cycles level_out stays low between two levels; legal range >= 1
MAX_PENDING, 3, maximum queued strobes; legal range 1 .. 2^PEND_W-1
PEND_W, 2, width of the pending counter
CNT_W, 8, width of the internal cycle counter; must hold max(HOLD_CYCLES, GAP_CYCLES)-1

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
strobe_n  input  1  active-low request; each cycle sampled low is exactly one request
clear_ovf  input  1  active-high; clears the overflow flag
level_out  output  1  registered stretched level, active-high
busy  output  1  high when state != IDLE
pending  output  PEND_W  registered count of queued requests
overflow  output  1  sticky; set when a request is dropped

Behaviour:
- Reset: reset high at a posedge puts the block in the following state on the next cycle: state=IDLE, level_out=0, busy=0, pending=0, overflow=0, counter=0. Reset overrides everything, including mid-HOLD and mid-GAP. No queued request survives reset.
- Define req = (strobe_n == 0) at the sampling edge.
- States: IDLE, HOLD, GAP. level_out = (state == HOLD), driven from a register with no combinational path from strobe_n.
- IDLE:
  - req -> HOLD, counter <= HOLD_CYCLES-1. level_out rises the cycle after the sampling edge (latency 1).
  - No req -> stay in IDLE.
  - pending is always 0 in IDLE.
- HOLD:
  - counter != 0 -> decrement.
  - counter == 0 -> GAP, counter <= GAP_CYCLES-1.
  - level_out is therefore high for exactly HOLD_CYCLES cycles.
- GAP:
  - counter != 0 -> decrement.
  - counter == 0 is the last gap cycle. Set launch = (pending != 0) || req.
  - launch -> HOLD, counter <= HOLD_CYCLES-1.
  - No launch -> IDLE.
- Pending update in HOLD and in GAP cycles other than the last: req increments pending.
- Pending update on the last GAP cycle: pending_next = pending + req - launch.
  - Simultaneous req and queued launch: pending unchanged.
  - req with pending == 0: launches directly, pending stays 0.
- Saturation: if an increment would exceed MAX_PENDING, pending holds at MAX_PENDING, the request is dropped, and overflow <= 1.
- Overflow flag:
  - Cleared only by clear_ovf or reset.
  - clear_ovf and a new drop in the same cycle: set wins, overflow = 1.
- Back-to-back:
  - Continuous strobe_n low for N cycles is N requests, subject to saturation.
  - Consecutive levels are always separated by exactly GAP_CYCLES low cycles when work is queued.
- Invariants (assertion targets):
  - level_out is never high for more or fewer than HOLD_CYCLES consecutive cycles.
  - Low gaps between levels are never shorter than GAP_CYCLES.
  - pending <= MAX_PENDING.

Test Plan:
- Reset then idle, strobe_n held high 20 cycles -> level_out=0, busy=0, pending=0, overflow=0 throughout.
- Single strobe_n low pulse at cycle 5 (defaults) -> level_out high cycles 6-9, low from cycle 10; busy high cycles 6-11, 0 at cycle 12; pending stays 0.
- Strobes at cycles 5 and 7 -> pending=1 at cycle 8; level_out high 6-9, low 10-11, high 12-15; pending=0 at cycle 12.
- strobe_n low continuously cycles 5-10 (6 requests) -> one level launched, pending saturates at 3, overflow=1 from cycle 10; exactly 4 levels total, each 4 high / 2 low; clear_ovf at cycle 40 -> overflow=0 at cycle 41.
- Strobe exactly on the last GAP cycle with pending=0 -> next level starts the following cycle; gap is exactly 2 cycles; pending never becomes 1.
- reset asserted at cycle 8, mid-HOLD with pending=2 -> cycle 9: level_out=0, state IDLE, pending=0, overflow=0; no replay afterwards.
